// File: rtl/pipeline_stall_controller_pkg.sv
// ============================================================================
// Module  : stall_ctrl_pkg
// Brief   : State encoding shared by the pipeline stall controller files.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stall_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
// ============================================================================
// Module  : pipeline_stall_controller_if
// Brief   : Hazard, SRAM handshake and stall-control bundle of the controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
) ();
  import stall_ctrl_pkg::*;

  logic                 forward_en;
  logic [3:0]           id_src1;
  logic [3:0]           id_src2;
  logic                 id_two_src;
  logic [3:0]           exe_dest;
  logic                 exe_wb_en;
  logic                 exe_mem_r_en;
  logic [3:0]           mem_dest;
  logic                 mem_wb_en;
  logic                 mem_req;
  logic                 sram_ready;
  logic                 branch_taken;
  logic                 sram_start;
  logic                 freeze_front;
  logic                 freeze_all;
  logic                 flush;
  logic                 mem_error;
  logic [STATE_W-1:0]   state;
  logic [CNT_W-1:0]     hazard_cycles;
  logic [CNT_W-1:0]     mem_wait_cycles;

  modport master (
    output forward_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
           exe_mem_r_en, mem_dest, mem_wb_en, mem_req, sram_ready, branch_taken,
    input  sram_start, freeze_front, freeze_all, flush, mem_error, state,
           hazard_cycles, mem_wait_cycles
  );

  modport slave (
    input  forward_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en,
           exe_mem_r_en, mem_dest, mem_wb_en, mem_req, sram_ready, branch_taken,
    output sram_start, freeze_front, freeze_all, flush, mem_error, state,
           hazard_cycles, mem_wait_cycles
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational RAW hazard compare between ID sources and EXE/MEM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect (
  input  wire logic       forward_en,
  input  wire logic [3:0] id_src1,
  input  wire logic [3:0] id_src2,
  input  wire logic       id_two_src,
  input  wire logic [3:0] exe_dest,
  input  wire logic       exe_wb_en,
  input  wire logic       exe_mem_r_en,
  input  wire logic [3:0] mem_dest,
  input  wire logic       mem_wb_en,
  output logic            hazard
);

  logic w_exe_m1;
  logic w_exe_m2;
  logic w_mem_hit;

  assign w_exe_m1  = (id_src1 == exe_dest) & exe_wb_en;
  assign w_exe_m2  = id_two_src & (id_src2 == exe_dest) & exe_wb_en;
  assign w_mem_hit = ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest))) & mem_wb_en;

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard = forward_en ? (exe_mem_r_en & (w_exe_m1 | w_exe_m2))
                             : (w_exe_m1 | w_exe_m2 | w_mem_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// Module  : pipeline_stall_controller
// Brief   : Stall/flush sequencer with SRAM handshake, watchdog and counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_controller
  import stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  pipeline_stall_controller_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_next;
  logic               r_mem_error;
  logic [CNT_W-1:0]   r_hazard_cycles;
  logic [CNT_W-1:0]   r_mem_wait_cycles;

  logic               w_hazard;
  logic               w_sram_start;
  logic               w_freeze_all;
  logic               w_flush;
  logic               w_freeze_front;
  logic               w_count_mem_wait;

  hazard_detect u_hazard_detect (
    .forward_en   (bus.forward_en),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_two_src   (bus.id_two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (w_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  // Outputs are forced low during reset so an in-flight access is never restarted.
  always_comb begin
    w_state_next     = r_state;
    w_wait_next      = r_wait_cnt;
    w_sram_start     = 1'b0;
    w_freeze_all     = 1'b0;
    w_count_mem_wait = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.mem_req) begin
          w_sram_start     = 1'b1;
          w_freeze_all     = 1'b1;
          w_count_mem_wait = 1'b1;
          w_state_next     = ST_MEM_WAIT;
          w_wait_next      = '0;
        end
      end
      ST_MEM_WAIT: begin
        w_freeze_all     = ~bus.sram_ready;
        w_count_mem_wait = ~bus.sram_ready;
        w_wait_next      = r_wait_cnt + WAIT_W'(1);
        if (bus.sram_ready) begin
          w_state_next = ST_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_ERROR: begin
        w_freeze_all = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
    if (rst) begin
      w_sram_start     = 1'b0;
      w_freeze_all     = 1'b0;
      w_count_mem_wait = 1'b0;
    end
  end

  assign w_flush        = bus.branch_taken & ~w_freeze_all & ~rst;
  assign w_freeze_front = w_hazard & ~w_freeze_all & ~bus.branch_taken & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_error       <= 1'b0;
      r_hazard_cycles   <= '0;
      r_mem_wait_cycles <= '0;
    end else begin
      if (w_state_next == ST_ERROR) begin
        r_mem_error <= 1'b1;
      end
      if (w_freeze_front && (r_hazard_cycles != '1)) begin
        r_hazard_cycles <= r_hazard_cycles + CNT_W'(1);
      end
      if (w_count_mem_wait && (r_mem_wait_cycles != '1)) begin
        r_mem_wait_cycles <= r_mem_wait_cycles + CNT_W'(1);
      end
    end
  end

  assign bus.sram_start      = w_sram_start;
  assign bus.freeze_all      = w_freeze_all;
  assign bus.flush           = w_flush;
  assign bus.freeze_front    = w_freeze_front;
  assign bus.mem_error       = r_mem_error;
  assign bus.state           = r_state;
  assign bus.hazard_cycles   = r_hazard_cycles;
  assign bus.mem_wait_cycles = r_mem_wait_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// ============================================================================
// Module  : tb_pipeline_stall_controller
// Brief   : Scoreboard bench with a cycle-level reference model of the controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_controller;

  localparam int TO = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       fwd;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic [3:0] ed;
    logic       ewb;
    logic       emr;
    logic [3:0] md;
    logic       mwb;
    logic       mreq;
    logic       rdy;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic       start;
    logic       ff;
    logic       fa;
    logic       flush;
    logic       merr;
    logic [1:0] st;
    logic [3:0] hc;
    logic [3:0] mc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Reference model: mode 0 = running, 1 = waiting on SRAM, 2 = dead until reset.
  int mode = 0;
  int waited = 0;
  int hc = 0;
  int mc = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic bit hazard_of(input stim_t s);
    bit exe_hit;
    bit mem_hit;
    exe_hit = s.ewb && ((s.s1 == s.ed) || (s.two && (s.s2 == s.ed)));
    mem_hit = s.mwb && ((s.s1 == s.md) || (s.two && (s.s2 == s.md)));
    return s.fwd ? (exe_hit && s.emr) : (exe_hit || mem_hit);
  endfunction

  task automatic apply(input stim_t s);
    bus.forward_en   = s.fwd;
    bus.id_src1      = s.s1;
    bus.id_src2      = s.s2;
    bus.id_two_src   = s.two;
    bus.exe_dest     = s.ed;
    bus.exe_wb_en    = s.ewb;
    bus.exe_mem_r_en = s.emr;
    bus.mem_dest     = s.md;
    bus.mem_wb_en    = s.mwb;
    bus.mem_req      = s.mreq;
    bus.sram_ready   = s.rdy;
    bus.branch_taken = s.br;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit busy;
    bit start;
    busy  = (mode == 2) || (mode == 0 && s.mreq) || (mode == 1 && !s.rdy);
    start = (mode == 0) && s.mreq;
    e.start = start;
    e.fa    = busy;
    e.flush = s.br && !busy;
    e.ff    = hazard_of(s) && !busy && !s.br;
    e.merr  = (mode == 2);
    e.st    = 2'(mode);
    e.hc    = 4'(hc);
    e.mc    = 4'(mc);
    if (e.ff) hc = (hc < CMAX) ? hc + 1 : CMAX;
    if (busy && mode != 2) mc = (mc < CMAX) ? mc + 1 : CMAX;
    if (mode == 0) begin
      if (s.mreq) begin
        mode = 1;
        waited = 0;
      end
    end else if (mode == 1) begin
      if (s.rdy) mode = 0;
      else begin
        waited++;
        if (waited >= TO) mode = 2;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    model_step(s, e);
    q.push_back(e);
  endtask

  // Asserts rst mid-cycle with the current inputs still applied, then idles.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_state", 8'(bus.state), 8'd0);
    chk("rst_hazard_cycles", 8'(bus.hazard_cycles), 8'd0);
    chk("rst_mem_wait_cycles", 8'(bus.mem_wait_cycles), 8'd0);
    chk("rst_outputs", {3'b0, bus.sram_start, bus.freeze_all, bus.freeze_front, bus.flush, bus.mem_error}, 8'd0);
    apply(idle());
    @(posedge clk);
    #3;
    rst = 1'b0;
    mode = 0;
    waited = 0;
    hc = 0;
    mc = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sram_start", 8'(bus.sram_start), 8'(e.start));
        chk("freeze_front", 8'(bus.freeze_front), 8'(e.ff));
        chk("freeze_all", 8'(bus.freeze_all), 8'(e.fa));
        chk("flush", 8'(bus.flush), 8'(e.flush));
        chk("mem_error", 8'(bus.mem_error), 8'(e.merr));
        chk("state", 8'(bus.state), 8'(e.st));
        chk("hazard_cycles", 8'(bus.hazard_cycles), 8'(e.hc));
        chk("mem_wait_cycles", 8'(bus.mem_wait_cycles), 8'(e.mc));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : driver
    stim_t s;
    stim_t hz;
    apply(idle());
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    drive(idle());

    hz = idle();
    hz.fwd = 1'b1; hz.ed = 4'd3; hz.emr = 1'b1; hz.ewb = 1'b1; hz.s1 = 4'd3;
    drive(hz);
    s = hz; s.emr = 1'b0;
    drive(s);

    s = idle(); s.md = 4'd5; s.mwb = 1'b1; s.two = 1'b1; s.s2 = 4'd5; s.s1 = 4'd1;
    drive(s);
    s.two = 1'b0;
    drive(s);

    s = idle(); s.mreq = 1'b1;
    repeat (4) drive(s);
    s.rdy = 1'b1;
    drive(s);
    drive(idle());

    s = idle(); s.mreq = 1'b1;
    drive(s);
    s.br = 1'b1;
    repeat (2) drive(s);
    s.rdy = 1'b1;
    drive(s);
    drive(idle());

    s = hz; s.br = 1'b1;
    drive(s);

    s = idle(); s.mreq = 1'b1;
    repeat (10) drive(s);
    s.rdy = 1'b1;
    drive(s);
    repeat (2) drive(idle());
    do_reset();

    repeat (20) drive(hz);
    drive(idle());

    s = idle(); s.mreq = 1'b1;
    repeat (3) drive(s);
    do_reset();
    drive(idle());

    for (int i = 0; i < 1500; i++) begin
      s.fwd  = 1'($urandom_range(0, 1));
      s.s1   = 4'($urandom_range(0, 3));
      s.s2   = 4'($urandom_range(0, 3));
      s.two  = 1'($urandom_range(0, 1));
      s.ed   = 4'($urandom_range(0, 3));
      s.ewb  = 1'($urandom_range(0, 1));
      s.emr  = 1'($urandom_range(0, 1));
      s.md   = 4'($urandom_range(0, 3));
      s.mwb  = 1'($urandom_range(0, 1));
      s.mreq = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 99) < 20);
      s.rdy  = 1'($urandom_range(0, 99) < 30);
      s.br   = 1'($urandom_range(0, 99) < 15);
      drive(s);
      if ((mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    chk("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central hazard and stall sequencer for the 5-stage ARM pipeline. It sits beside the forwarding unit and decides, each cycle, whether IF/ID freeze for a data hazard, whether the whole pipeline freezes for an SRAM access, and when the IF/ID and ID/EXE stages are flushed for a taken branch. It owns the SRAM start/ready handshake, a memory-wait watchdog and saturating performance counters.

Parameters:
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before the watchdog fires (must be >= 2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
forward_en  in  1  1 = forwarding unit active (only load-use stalls); 0 = no forwarding
id_src1, id_src2  in  4  source registers of the instruction in ID
id_two_src  in  1  ID instruction reads id_src2
exe_dest  in  4  destination register in EXE
exe_wb_en, exe_mem_r_en  in  1  EXE writes back / EXE is a load
mem_dest  in  4  destination register in MEM
mem_wb_en  in  1  MEM writes back
mem_req  in  1  MEM-stage instruction is a load or store (level)
sram_ready  in  1  SRAM controller: access complete (1-cycle pulse)
branch_taken  in  1  taken branch resolved in EXE
sram_start  out  1  1-cycle pulse starting an SRAM access
freeze_front  out  1  hold PC and IF/ID; ID/EXE loads a bubble
freeze_all  out  1  hold every pipeline register
flush  out  1  clear IF/ID and ID/EXE
mem_error  out  1  sticky watchdog flag
state  out  2  current FSM state
hazard_cycles, mem_wait_cycles  out  CNT_W  saturating counters

Behaviour:
- Reset (async): state=RUN, wait counter=0, both counters=0, mem_error=0. All combinational outputs are 0 while in RUN with all inputs idle.
- States: RUN=0, MEM_WAIT=1, ERROR=2. Encoding 3 is unused and returns to RUN.
- Hazard (combinational): m1 = (id_src1==exe_dest)&exe_wb_en; m2 = id_two_src&(id_src2==exe_dest)&exe_wb_en.
  - forward_en=1: hazard = exe_mem_r_en&(m1|m2).
  - forward_en=0: hazard = m1|m2|((id_src1==mem_dest)|(id_two_src&(id_src2==mem_dest)))&mem_wb_en.
- RUN:
  - If mem_req: sram_start=1, freeze_all=1, next state MEM_WAIT, wait counter cleared.
  - Otherwise freeze_all=0.
- MEM_WAIT:
  - freeze_all = !sram_ready; sram_start=0; wait counter increments each cycle.
  - On sram_ready the pipeline advances that same cycle and the next state is RUN. A still-high mem_req in RUN then belongs to the next instruction and starts a new access.
  - If the wait counter reaches MEM_TIMEOUT-1 without sram_ready: next state ERROR.
  - sram_ready outside MEM_WAIT is ignored.
- ERROR: freeze_all=1, mem_error=1. The block stays here until rst.
- Priority per cycle, highest first:
  1. freeze_all. flush=0 and freeze_front=0 whenever freeze_all=1. A branch_taken is held by the frozen EXE register and is acted on when the pipeline releases.
  2. flush = branch_taken&!freeze_all. It suppresses freeze_front because the ID instruction is being discarded.
  3. freeze_front = hazard&!freeze_all&!branch_taken.
- Counters:
  - hazard_cycles increments on each cycle with freeze_front=1.
  - mem_wait_cycles increments on each cycle with freeze_all=1 in RUN or MEM_WAIT.
  - Both saturate at all-ones; neither wraps.
- Reset asserted mid-access: FSM returns to RUN immediately, sram_start is not reissued, counters clear.

Decomposition:
- Package stall_ctrl_pkg holds the state encoding constants (RUN/MEM_WAIT/ERROR) and the 2-bit state width.
- One combinational sub-module, hazard_detect, covers the compare logic above. The top level holds the FSM, watchdog counter and perf counters.

Test Plan:
1. forward_en=1; EXE load (exe_dest=3, exe_mem_r_en=1, exe_wb_en=1); ID src1=3 -> freeze_front=1 for that cycle, hazard_cycles 0->1. Same case with exe_mem_r_en=0 -> freeze_front=0.
2. forward_en=0; mem_dest=5, mem_wb_en=1; id_two_src=1, id_src2=5 -> freeze_front=1. Same case with id_two_src=0 -> freeze_front=0.
3. mem_req=1 in RUN; sram_ready pulsed 4 cycles later:
   - sram_start is high for exactly 1 cycle.
   - freeze_all is high for 4 cycles, then drops the cycle sram_ready=1.
   - State goes RUN->MEM_WAIT->RUN; mem_wait_cycles=4.
4. branch_taken=1 during MEM_WAIT -> flush=0 until the sram_ready cycle, then flush=1. branch_taken together with a hazard in RUN -> flush=1, freeze_front=0.
5. MEM_TIMEOUT=8, sram_ready never asserted -> ERROR after 8 wait cycles. mem_error=1 and freeze_all=1 persist, and a late sram_ready has no effect. rst -> all outputs 0, state=RUN.
6. CNT_W=4 with a hazard held for 20 cycles -> hazard_cycles saturates at 15. rst asserted mid-MEM_WAIT -> state=RUN asynchronously, counters=0.
